// File: rtl/memory_stage.sv
// memory_stage: execute->memory consumer. It registers ALU results for
// writeback and runs a single outstanding req/ack transaction on the
// data-memory port for LOAD/STORE. Execute is stalled while that
// transaction is outstanding.
//
// state  | meaning
// IDLE   | ready to accept an instruction from execute
// WAIT   | dmem request outstanding, waiting for ack or timeout
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INST_TYPE_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   execute_memory_valid,
  input  logic [6:0]             execute_memory_opcode,
  input  logic [INST_TYPE_W-1:0] execute_memory_inst_type,
  input  logic [2:0]             execute_memory_funct3,
  input  logic [6:0]             execute_memory_funct7,
  input  logic [4:0]             execute_memory_rd,
  input  logic [31:0]            execute_memory_rd_data,
  input  logic [31:0]            execute_memory_rs2_data,
  output logic                   memory_execute_stall,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic                   memory_writeback_valid,
  output logic [INST_TYPE_W-1:0] memory_writeback_inst_type,
  output logic [4:0]             memory_writeback_rd,
  output logic                   memory_writeback_rd_we,
  output logic [31:0]            memory_writeback_rd_data,
  output logic                   memory_writeback_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the limit cycle itself
  // is the last WAIT cycle in which an ack is still honoured.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [2:0]             ld_f3_q, ld_f3_d;
  logic [1:0]             ld_off_q, ld_off_d;
  logic [4:0]             pend_rd_q, pend_rd_d;
  logic [31:0]            pend_alu_q, pend_alu_d;
  logic [INST_TYPE_W-1:0] pend_type_q, pend_type_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [INST_TYPE_W-1:0] wb_type_q, wb_type_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic                   wb_rd_we_q, wb_rd_we_d;
  logic [31:0]            wb_data_q, wb_data_d;
  logic                   wb_fault_q, wb_fault_d;

  logic        is_load, is_store, is_mem, f3_legal, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        to_hit;

  // funct7 is not needed by this stage
  logic unused_funct7;
  assign unused_funct7 = ^execute_memory_funct7;

  assign is_load  = (execute_memory_opcode == OP_LOAD);
  assign is_store = (execute_memory_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

  // Decode access legality and alignment of the incoming instruction
  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      case (execute_memory_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (execute_memory_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
    misaligned = ((execute_memory_funct3[1:0] == 2'b01) && execute_memory_rd_data[0]) ||
                 ((execute_memory_funct3[1:0] == 2'b10) && (execute_memory_rd_data[1:0] != 2'b00));
  end

  // Store lane enables and replicated write data
  always_comb begin
    case (execute_memory_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << execute_memory_rd_data[1:0];
        st_wdata = {4{execute_memory_rs2_data[7:0]}};
      end
      2'b01: begin
        st_be    = execute_memory_rd_data[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{execute_memory_rs2_data[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = execute_memory_rs2_data;
      end
    endcase
  end

  // Lane select and sign/zero extension of returned load data
  always_comb begin
    case (ld_off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign to_hit = TIMEOUT_EN && (cnt_q == LIMIT_C);

  // Next-state and registered-output logic for IDLE/WAIT
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    pend_rd_d   = pend_rd_q;
    pend_alu_d  = pend_alu_q;
    pend_type_d = pend_type_q;
    wb_valid_d  = 1'b0;
    wb_type_d   = wb_type_q;
    wb_rd_d     = wb_rd_q;
    wb_rd_we_d  = wb_rd_we_q;
    wb_data_d   = wb_data_q;
    wb_fault_d  = wb_fault_q;

    if (state_q == S_IDLE) begin
      if (execute_memory_valid) begin
        if (is_mem && f3_legal && !misaligned) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          req_d       = 1'b1;
          we_d        = is_store;
          addr_d      = {execute_memory_rd_data[31:2], 2'b00};
          be_d        = is_store ? st_be : 4'hF;
          wdata_d     = st_wdata;
          ld_f3_d     = execute_memory_funct3;
          ld_off_d    = execute_memory_rd_data[1:0];
          pend_rd_d   = execute_memory_rd;
          pend_alu_d  = execute_memory_rd_data;
          pend_type_d = execute_memory_inst_type;
        end else begin
          // ALU result, or a memory op rejected without touching dmem
          wb_valid_d = 1'b1;
          wb_type_d  = execute_memory_inst_type;
          wb_rd_d    = execute_memory_rd;
          wb_data_d  = execute_memory_rd_data;
          wb_fault_d = is_mem;
          wb_rd_we_d = !is_mem && (execute_memory_rd != 5'd0);
        end
      end
    end else begin
      if (dmem_ack) begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        wb_valid_d = 1'b1;
        wb_type_d  = pend_type_q;
        wb_rd_d    = pend_rd_q;
        wb_fault_d = 1'b0;
        wb_rd_we_d = !we_q && (pend_rd_q != 5'd0);
        wb_data_d  = we_q ? pend_alu_q : ld_data;
      end else if (to_hit) begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        wb_valid_d = 1'b1;
        wb_type_d  = pend_type_q;
        wb_rd_d    = pend_rd_q;
        wb_fault_d = 1'b1;
        wb_rd_we_d = 1'b0;
        wb_data_d  = pend_alu_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      pend_rd_q   <= '0;
      pend_alu_q  <= '0;
      pend_type_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_type_q   <= '0;
      wb_rd_q     <= '0;
      wb_rd_we_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      pend_rd_q   <= pend_rd_d;
      pend_alu_q  <= pend_alu_d;
      pend_type_q <= pend_type_d;
      wb_valid_q  <= wb_valid_d;
      wb_type_q   <= wb_type_d;
      wb_rd_q     <= wb_rd_d;
      wb_rd_we_q  <= wb_rd_we_d;
      wb_data_q   <= wb_data_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign memory_execute_stall       = (state_q == S_WAIT);
  assign dmem_req                   = req_q;
  assign dmem_we                    = we_q;
  assign dmem_addr                  = addr_q;
  assign dmem_be                    = be_q;
  assign dmem_wdata                 = wdata_q;
  assign memory_writeback_valid     = wb_valid_q;
  assign memory_writeback_inst_type = wb_type_q;
  assign memory_writeback_rd        = wb_rd_q;
  assign memory_writeback_rd_we     = wb_rd_we_q;
  assign memory_writeback_rd_data   = wb_data_q;
  assign memory_writeback_fault     = wb_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: table of single-instruction vectors plus
// hand-written timeout and reset-during-WAIT sequences. Writeback pulses
// are checked against a queue of expected results.
module tb_memory_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_op = '0;
  logic [2:0]  ex_it = '0;
  logic [2:0]  ex_f3 = '0;
  logic [6:0]  ex_f7 = '0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_rs2 = '0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_rd_we, wb_fault;
  logic [2:0]  wb_it;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(4), .INST_TYPE_W(3)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .execute_memory_valid       (ex_valid),
    .execute_memory_opcode      (ex_op),
    .execute_memory_inst_type   (ex_it),
    .execute_memory_funct3      (ex_f3),
    .execute_memory_funct7      (ex_f7),
    .execute_memory_rd          (ex_rd),
    .execute_memory_rd_data     (ex_alu),
    .execute_memory_rs2_data    (ex_rs2),
    .memory_execute_stall       (stall),
    .dmem_req                   (dmem_req),
    .dmem_we                    (dmem_we),
    .dmem_addr                  (dmem_addr),
    .dmem_be                    (dmem_be),
    .dmem_wdata                 (dmem_wdata),
    .dmem_ack                   (dmem_ack),
    .dmem_rdata                 (dmem_rdata),
    .memory_writeback_valid     (wb_valid),
    .memory_writeback_inst_type (wb_it),
    .memory_writeback_rd        (wb_rd),
    .memory_writeback_rd_we     (wb_rd_we),
    .memory_writeback_rd_data   (wb_data),
    .memory_writeback_fault     (wb_fault)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [2:0]  it;
    logic [31:0] alu;
    logic [31:0] rs2;
    int          dly;
    logic [31:0] rdata;
    logic        ereq;
    logic        ewe;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        erdwe;
    logic [31:0] edata;
    logic        efault;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [2:0]  it;
    logic        rdwe;
    logic [31:0] data;
    logic        fault;
  } wb_t;

  wb_t  sb_q[$];
  wb_t  mon_e;
  vec_t vecs[17];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [2:0] it, input logic [31:0] alu,
                              input logic [31:0] rs2, input int dly, input logic [31:0] rdata,
                              input logic ereq, input logic ewe, input logic [31:0] eaddr,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic erdwe,
                              input logic [31:0] edata, input logic efault);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.rd = rd; v.it = it; v.alu = alu; v.rs2 = rs2;
    v.dly = dly; v.rdata = rdata; v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ebe = ebe;
    v.ewd = ewd; v.erdwe = erdwe; v.edata = edata; v.efault = efault;
    return v;
  endfunction

  // Writeback monitor: every pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got pulse rd=%0d data=%h, expected no pulse", wb_rd, wb_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.name, "_wb_rd"},    32'(wb_rd),    32'(mon_e.rd));
        chk({mon_e.name, "_wb_it"},    32'(wb_it),    32'(mon_e.it));
        chk({mon_e.name, "_wb_rd_we"}, 32'(wb_rd_we), 32'(mon_e.rdwe));
        chk({mon_e.name, "_wb_fault"}, 32'(wb_fault), 32'(mon_e.fault));
        if (!mon_e.fault) chk({mon_e.name, "_wb_data"}, wb_data, mon_e.data);
      end
    end
  end

  task automatic drive(input vec_t v);
    ex_valid = 1'b1; ex_op = v.op; ex_f3 = v.f3; ex_rd = v.rd; ex_it = v.it;
    ex_alu = v.alu; ex_rs2 = v.rs2; ex_f7 = 7'($urandom);
  endtask

  task automatic push_exp(input vec_t v);
    wb_t e;
    e.name = v.name; e.rd = v.rd; e.it = v.it; e.rdwe = v.erdwe; e.data = v.edata; e.fault = v.efault;
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    push_exp(v);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (v.ereq) begin
      chk({v.name, "_req"},   32'(dmem_req), 32'd1);
      chk({v.name, "_we"},    32'(dmem_we),  32'(v.ewe));
      chk({v.name, "_addr"},  dmem_addr,     v.eaddr);
      chk({v.name, "_be"},    32'(dmem_be),  32'(v.ebe));
      if (v.ewe) chk({v.name, "_wdata"}, dmem_wdata, v.ewd);
      chk({v.name, "_stall"}, 32'(stall),    32'd1);
      repeat (v.dly) begin
        @(posedge clk); #1;
        chk({v.name, "_req_hold"},   32'(dmem_req), 32'd1);
        chk({v.name, "_stall_hold"}, 32'(stall),    32'd1);
      end
      dmem_ack = 1'b1;
      dmem_rdata = v.rdata;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      chk({v.name, "_req_drop"},  32'(dmem_req), 32'd0);
      chk({v.name, "_wb_pulse"},  32'(wb_valid), 32'd1);
      chk({v.name, "_stall_end"}, 32'(stall),    32'd0);
    end else begin
      chk({v.name, "_no_req"},   32'(dmem_req), 32'd0);
      chk({v.name, "_wb_pulse"}, 32'(wb_valid), 32'd1);
      chk({v.name, "_no_stall"}, 32'(stall),    32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = mk("add",       OP_ALU,   3'b000, 5'd5,  3'd1, 32'h0000_1234, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
    vecs[1]  = mk("add_rd0",   OP_ALU,   3'b000, 5'd0,  3'd1, 32'hDEAD_BEEF, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mk("lb",        OP_LOAD,  3'b000, 5'd7,  3'd2, 32'h0000_0103, 32'h0, 3, 32'h8000_0000,
                 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    vecs[3]  = mk("lbu",       OP_LOAD,  3'b100, 5'd8,  3'd2, 32'h0000_0103, 32'h0, 3, 32'h8000_0000,
                 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
    vecs[4]  = mk("sh",        OP_STORE, 3'b001, 5'd9,  3'd3, 32'h0000_0202, 32'hABCD_1234, 1, 32'h0,
                 1'b1, 1'b1, 32'h200, 4'b1100, 32'h1234_1234, 1'b0, 32'h0000_0202, 1'b0);
    vecs[5]  = mk("lw_mis",    OP_LOAD,  3'b010, 5'd6,  3'd2, 32'h0000_0101, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    vecs[6]  = mk("ld_f3_011", OP_LOAD,  3'b011, 5'd6,  3'd2, 32'h0000_0100, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    vecs[7]  = mk("lh_hi",     OP_LOAD,  3'b001, 5'd10, 3'd2, 32'h0000_0402, 32'h0, 0, 32'h8001_7FFF,
                 1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
    vecs[8]  = mk("lhu_lo",    OP_LOAD,  3'b101, 5'd11, 3'd2, 32'h0000_0400, 32'h0, 2, 32'h8001_F00D,
                 1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b1, 32'h0000_F00D, 1'b0);
    vecs[9]  = mk("lw",        OP_LOAD,  3'b010, 5'd12, 3'd2, 32'h0000_0500, 32'h0, 0, 32'hCAFE_F00D,
                 1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    vecs[10] = mk("sb",        OP_STORE, 3'b000, 5'd1,  3'd3, 32'h0000_0601, 32'h0000_00A5, 0, 32'h0,
                 1'b1, 1'b1, 32'h600, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0000_0601, 1'b0);
    vecs[11] = mk("sw",        OP_STORE, 3'b010, 5'd2,  3'd3, 32'h0000_0704, 32'h1122_3344, 2, 32'h0,
                 1'b1, 1'b1, 32'h704, 4'hF, 32'h1122_3344, 1'b0, 32'h0000_0704, 1'b0);
    vecs[12] = mk("lb_pos",    OP_LOAD,  3'b000, 5'd13, 3'd2, 32'h0000_0102, 32'h0, 1, 32'h0012_3456,
                 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'h0000_0012, 1'b0);
    vecs[13] = mk("lw_rd0",    OP_LOAD,  3'b010, 5'd0,  3'd2, 32'h0000_0800, 32'h0, 0, 32'h0000_0001,
                 1'b1, 1'b0, 32'h800, 4'hF, 32'h0, 1'b0, 32'h0000_0001, 1'b0);
    vecs[14] = mk("st_f3_011", OP_STORE, 3'b011, 5'd4,  3'd3, 32'h0000_0100, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    vecs[15] = mk("sh_mis",    OP_STORE, 3'b001, 5'd4,  3'd3, 32'h0000_0203, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    vecs[16] = mk("ld_f3_110", OP_LOAD,  3'b110, 5'd4,  3'd2, 32'h0000_0100, 32'h0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall",    32'(stall),    32'd0);
    chk("rst_req",      32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data",  wb_data,       32'd0);
    chk("rst_addr",     dmem_addr,     32'd0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Writeback fields hold between pulses
    @(posedge clk); #1;
    chk("hold_wb_valid", 32'(wb_valid), 32'd0);
    chk("hold_wb_rd",    32'(wb_rd),    32'd4);
    chk("hold_wb_fault", 32'(wb_fault), 32'd1);

    // Timeout: no ack, request visible for 4 cycles, then fault pulse
    v = mk("timeout", OP_LOAD, 3'b010, 5'd14, 3'd5, 32'h0000_0300, 32'h0, 0, 32'h0,
           1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    drive(v);
    push_exp(v);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("timeout_req_high", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("timeout_req_drop", 32'(dmem_req), 32'd0);
    chk("timeout_wb_pulse", 32'(wb_valid), 32'd1);
    chk("timeout_idle",     32'(stall),    32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_no_pulse", 32'(wb_valid), 32'd0);
    chk("late_ack_no_req",   32'(dmem_req), 32'd0);
    chk("late_ack_no_stall", 32'(stall),    32'd0);

    // Reset while WAIT: request drops at once, nothing written back
    v = mk("rst_wait", OP_LOAD, 3'b010, 5'd15, 3'd2, 32'h0000_0900, 32'h0, 0, 32'h0,
           1'b1, 1'b0, 32'h900, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rst_wait_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_wait_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_wait_stall",    32'(stall),    32'd0);
    chk("rst_wait_addr",     dmem_addr,     32'd0);
    chk("rst_wait_wb_data",  wb_data,       32'd0);
    chk("rst_wait_wb_rd",    32'(wb_rd),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0]);
    run_vec(vecs[9]);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
